// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs PACK_RATIO FIFO entries into one wide stream word (optional PACKER_FLUSH_TIMEOUT_EN)
module fifo_word_packer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PACK_RATIO     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rstn,
    output logic                             fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
    input  logic                             fifo_rd_empty,
    input  logic                             flush,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
    output logic [PACK_RATIO-1:0]            m_keep
);

    localparam int WW = DATA_WIDTH * PACK_RATIO;
    localparam int CW = $clog2(PACK_RATIO + 1);
    localparam logic [CW:0] RATIO_W = (CW + 1)'(PACK_RATIO);
    localparam logic [CW-1:0] LAST_LANE = CW'(PACK_RATIO - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        OUT     = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [WW-1:0]         data_q, data_d;
    logic                  m_valid_q, m_valid_d;
    logic [PACK_RATIO-1:0] m_keep_q, m_keep_d;
    logic [CW:0]           occupancy;
    logic                  timeout_hit;
    logic                  flush_req;

`ifdef PACKER_FLUSH_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle_q, idle_d;

    assign timeout_hit = (idle_q == IW'(TIMEOUT_CYCLES));

    // Idle counter: restarts on every capture or when nothing is buffered, saturates at the limit
    always_comb begin
        idle_d = idle_q;
        if (state_q != COLLECT || count_q == '0 || inflight_q) begin
            idle_d = '0;
        end else if (!timeout_hit) begin
            idle_d = idle_q + IW'(1);
        end
    end

    // Idle counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Entries already owned by the packer: captured lanes plus the pop still in flight
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign flush_req = flush || timeout_hit;

    assign fifo_rd_en = (state_q == COLLECT) && !fifo_rd_empty && (occupancy < RATIO_W)
                        && !flush_pend_q;

    assign m_valid = m_valid_q;
    assign m_data  = data_q;
    assign m_keep  = m_keep_q;

    // Next-state: capture landing entries, close the word when full or flushed, drain on handshake
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        inflight_d   = fifo_rd_en;
        flush_pend_d = flush_pend_q;
        data_d       = data_q;
        m_valid_d    = m_valid_q;
        m_keep_d     = m_keep_q;
        case (state_q)
            COLLECT: begin
                if (inflight_q) begin
                    for (int i = 0; i < PACK_RATIO; i++) begin
                        if (count_q == CW'(i)) begin
                            data_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
                        end
                    end
                    count_d = count_q + CW'(1);
                end
                if (inflight_q && count_q == LAST_LANE) begin
                    // A full word wins over any concurrent or pending flush
                    state_d      = OUT;
                    m_valid_d    = 1'b1;
                    m_keep_d     = '1;
                    flush_pend_d = 1'b0;
                end else if ((flush_req || flush_pend_q) && occupancy != '0) begin
                    if (!inflight_q && !fifo_rd_en) begin
                        state_d      = OUT;
                        m_valid_d    = 1'b1;
                        flush_pend_d = 1'b0;
                        for (int i = 0; i < PACK_RATIO; i++) begin
                            m_keep_d[i] = (CW'(i) < count_q);
                        end
                    end else begin
                        // An entry is still on its way; emit once it has landed
                        flush_pend_d = 1'b1;
                    end
                end
            end
            OUT: begin
                inflight_d = 1'b0;
                if (m_ready) begin
                    state_d   = COLLECT;
                    count_d   = '0;
                    data_d    = '0;
                    m_valid_d = 1'b0;
                    m_keep_d  = '0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // State and registered outputs; reset discards any partial word and in-flight entry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= COLLECT;
            count_q      <= '0;
            inflight_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            data_q       <= '0;
            m_valid_q    <= 1'b0;
            m_keep_q     <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            flush_pend_q <= flush_pend_d;
            data_q       <= data_d;
            m_valid_q    <= m_valid_d;
            m_keep_q     <= m_keep_d;
        end
    end

endmodule
